sram_1rw_req_ctrl_freepdk45: RTL and testbench

//  Upstream driver for the single-port 1rw SRAM macro (sram_1rw_64b_1024w_1bank_freepdk45).
//  - Converts a valid/ready request stream (read/write) into the macro's active-low CSb/WEb/OEb controls.
//  - Owns the shared bidirectional DATA bus.
//  - Captures read data into a response FIFO drained by a valid/ready response port.

---
 rtl/sram_1rw_req_ctrl_freepdk45_if.sv | 61 ++++++
 rtl/sram_1rw_req_ctrl_freepdk45.sv | 201 ++++++++++++++++++++
 tb/tb_sram_1rw_req_ctrl_freepdk45.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_1rw_req_ctrl_freepdk45_if.sv
// ---------------------------------------------------------------------------
// sram_1rw_req_ctrl_freepdk45_if
//
// Purpose:
//   Groups the request and response streams of the 1rw SRAM request
//   controller into one bundle.
//
// Handshake semantics (both streams):
//   A transfer happens at a rising clk edge where valid && ready are both
//   high. Once valid is raised, the producer holds valid and the payload
//   steady until that transfer. ready may depend combinationally on valid
//   and the payload. valid never depends on ready.
//
// Signals:
//   req_valid / req_ready  request handshake (master -> controller)
//   req_we                 1 = write, 0 = read
//   req_addr               word address
//   req_wdata              write data
//   rsp_valid / rsp_ready  response handshake (controller -> master)
//   rsp_rdata              read data at the head of the response FIFO
//
// Modports:
//   master  the request producer / response consumer
//   slave   the controller
// ---------------------------------------------------------------------------
interface sram_1rw_req_ctrl_freepdk45_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        output rsp_ready
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        input  rsp_ready
    );
endinterface

// File: rtl/sram_1rw_req_ctrl_freepdk45.sv
// ---------------------------------------------------------------------------
// sram_1rw_req_ctrl_freepdk45
//
// Purpose:
//   Upstream driver for the single-port 1rw SRAM macro
//   sram_1rw_64b_1024w_1bank_freepdk45. It turns a valid/ready request
//   stream into the macro's registered active-low CSb/WEb/OEb controls. It
//   owns the shared bidirectional DATA bus. Read data is captured into a
//   small response FIFO, and a valid/ready response port drains that FIFO.
//
// Ports:
//   clk        single clock (the macro runs on the same clock)
//   rst        synchronous, active-high reset
//   bus        request/response streams (slave side of the interface)
//   sram_addr  registered word address to the macro
//   sram_csb   registered chip select, active low
//   sram_web   registered write enable, active low
//   sram_oeb   registered output enable, active low
//   sram_data  shared DATA bus. Driven with the write-data register only
//              while sram_web == 0, otherwise released to 'z
//   dbg_state  current FSM state encoding {turn, csb, web, oeb}
//
// Timing:
//   A request accepted at edge t is presented to the macro during cycle t.
//   The macro samples the command at edge t+1.
//   For a read, the macro drives DATA during cycle t+1, and the word is
//   pushed into the FIFO at edge t+2. That gives an accept -> rsp_valid
//   latency of 2 cycles when the FIFO is empty.
// ---------------------------------------------------------------------------
module sram_1rw_req_ctrl_freepdk45 #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    sram_1rw_req_ctrl_freepdk45_if.slave  bus,
    output logic [ADDR_WIDTH-1:0]         sram_addr,
    output logic                          sram_csb,
    output logic                          sram_web,
    output logic                          sram_oeb,
    inout  wire  [DATA_WIDTH-1:0]         sram_data,
    output logic [3:0]                    dbg_state
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // The state encoding carries the macro command bits directly, so that
    // csb/web/oeb come straight off flops with no decode logic in between.
    // The top bit only separates TURN from RD. Both present a read to the
    // macro, but TURN's data is never captured.
    typedef enum logic [3:0] {
        ST_IDLE = 4'b0111,
        ST_RD   = 4'b0010,
        ST_WR   = 4'b0001,
        ST_TURN = 4'b1010
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  cap_pend_q;  // macro sampled a real read at the last edge

    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      occ_q;

    logic                  state_is_rd;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  rsp_valid_int;
    logic [CNT_W:0]        credit_used;
    logic                  credit_ok;

    assign state_is_rd = (state_q == ST_RD);
    assign accept      = bus.req_valid && bus.req_ready;
    assign push        = cap_pend_q;
    assign rsp_valid_int = (occ_q != '0);
    assign pop         = rsp_valid_int && bus.rsp_ready;

    // Credits count queued words plus every accepted read not yet pushed.
    // There are two of those in a back-to-back stream: the one presented
    // this cycle (state RD) and the one the macro is returning this cycle
    // (cap_pend_q).
    // A pop in the same cycle is deliberately ignored here. The slot is
    // only reclaimed once occ_q has dropped.
    assign credit_used = {1'b0, occ_q}
                       + (CNT_W+1)'(state_is_rd)
                       + (CNT_W+1)'(cap_pend_q);
    assign credit_ok   = (credit_used < (CNT_W+1)'(RSP_DEPTH));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // A write arriving while a read is presented cannot go straight to WR.
    // WR would pull web low and drive DATA in the very cycle the macro is
    // returning the read word. TURN keeps web high for that cycle by
    // re-presenting the same read, which is harmless.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = ST_IDLE;
        if (accept) begin
            state_d = bus.req_we ? ST_WR : ST_RD;
        end else if (state_is_rd && bus.req_valid && bus.req_we) begin
            state_d = ST_TURN;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        sram_csb      = state_q[2];
        sram_web      = state_q[1];
        sram_oeb      = state_q[0];
        dbg_state     = state_q;
        // Writes bypass the credit check: they never produce a response.
        bus.req_ready = !rst
                      && !(state_is_rd && bus.req_we)
                      && (bus.req_we || credit_ok);
    end

    // ------------------------------------------------------------------
    // Command datapath and read-capture tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_addr  <= '0;
            wdata_q    <= '0;
            cap_pend_q <= 1'b0;
        end else begin
            // TURN is not a real read, so it never arms a capture.
            cap_pend_q <= state_is_rd;
            if (accept) begin
                sram_addr <= bus.req_addr;
                wdata_q   <= bus.req_wdata;
            end
        end
    end

    // The controller drives DATA only while presenting a write. The macro
    // drives only for reads, which hold web high, so the two drivers are
    // keyed off the same flops and cannot overlap.
    assign sram_data = (sram_web == 1'b0) ? wdata_q : {DATA_WIDTH{1'bz}};

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= sram_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + CNT_W'(1);
                2'b01:   occ_q <= occ_q - CNT_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // The head is gated so that an empty FIFO presents zero rather than a
    // stale or uninitialised entry.
    assign bus.rsp_valid = rsp_valid_int;
    assign bus.rsp_rdata = rsp_valid_int ? fifo_mem[rd_ptr_q] : '0;

    // The credit rule makes a push into a full FIFO unreachable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && (occ_q == CNT_W'(RSP_DEPTH))));
        end
    end

endmodule

// File: tb/tb_sram_1rw_req_ctrl_freepdk45.sv
// ---------------------------------------------------------------------------
// tb_sram_1rw_req_ctrl_freepdk45
//
// Directed bench for the 1rw SRAM request controller.
//
// A small behavioural model of the macro sits on the SRAM pins:
// - It samples the command at each rising edge.
// - It writes DATA on a sampled write.
// - On a sampled read, it drives the addressed word onto DATA 3 time units
//   after the edge. It keeps driving for the following cycle, while WEb
//   remains high.
//
// Inputs are driven on the falling edge, and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_sram_1rw_req_ctrl_freepdk45;
    localparam int DW    = 64;
    localparam int AW    = 10;
    localparam int DEPTH = 4;

    // -------------------- clock / reset --------------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wire  [DW-1:0] sram_data;
    logic [AW-1:0] sram_addr;
    logic          sram_csb;
    logic          sram_web;
    logic          sram_oeb;
    logic [3:0]    dbg_state;

    sram_1rw_req_ctrl_freepdk45_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sram_1rw_req_ctrl_freepdk45 #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RSP_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sram_addr (sram_addr),
        .sram_csb  (sram_csb),
        .sram_web  (sram_web),
        .sram_oeb  (sram_oeb),
        .sram_data (sram_data),
        .dbg_state (dbg_state)
    );

    // -------------------- macro model --------------------
    logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
    logic          mdl_rd_q = 1'b0;
    logic [DW-1:0] mdl_dout = '0;

    always @(posedge clk) begin
        mdl_rd_q <= !sram_csb && sram_web && !sram_oeb;
        if (!sram_csb && sram_web && !sram_oeb) mdl_dout <= #3 mdl_mem[sram_addr];
        if (!sram_csb && !sram_web) mdl_mem[sram_addr] <= sram_data;
    end

    assign sram_data = (mdl_rd_q && sram_web) ? mdl_dout : {DW{1'bz}};

    // -------------------- scoreboard --------------------
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_mem [0:(1<<AW)-1];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_rsp    = 0;
    bit last_acc;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock. Just before the edge, log any request accept into
    // the scoreboard, and compare any response pop against the expected queue.
    task automatic step();
        #1;
        last_acc = bus.req_valid && bus.req_ready;
        if (last_acc) begin
            if (bus.req_we) exp_mem[bus.req_addr] = bus.req_wdata;
            else            exp_q.push_back(exp_mem[bus.req_addr]);
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            n_rsp = n_rsp + 1;
            check("rsp_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("rsp_data", bus.rsp_rdata, exp_q.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // -------------------- driver tasks --------------------
    // Present a request that must be accepted at the very next edge.
    task automatic issue_now(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input string tag);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        #1 check(tag, bus.req_ready, 1);
        step();
    endtask

    // Present a request and wait (bounded) until it is accepted.
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit done = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int k = 0; k < 16 && !done; k++) begin
            step();
            done = last_acc;
        end
        check("issue_accepted", done, 1);
        bus.req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) step();
    endtask

    // -------------------- directed sequence --------------------
    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        // Reset held 3 cycles with a request pending.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_cmd", {sram_csb, sram_web, sram_oeb}, 3'b111);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_addr", sram_addr, 0);

        // Write 0x0123456789ABCDEF @ 0x3FF, then read it back.
        rst           = 1'b0;
        bus.rsp_ready = 1'b1;
        issue_now(1'b1, 10'h3FF, 64'h0123456789ABCDEF, "first_accept_ready");
        check("wr_cmd", {sram_csb, sram_web, sram_oeb}, 3'b001);
        check("wr_addr", sram_addr, 10'h3FF);
        check("wr_bus", sram_data, 64'h0123456789ABCDEF);
        issue_now(1'b0, 10'h3FF, 64'h0, "rd_after_wr_ready");
        check("rd_cmd", {sram_csb, sram_web, sram_oeb}, 3'b010);
        check("rd_lat_c0", bus.rsp_valid, 0);
        idle(1);
        check("rd_lat_c1", bus.rsp_valid, 0);
        idle(1);
        check("rd_lat_c2", bus.rsp_valid, 1);
        check("rd_lat_data", bus.rsp_rdata, 64'h0123456789ABCDEF);
        idle(2);

        // Writes of 0xA0..0xA3 @ 0..3, then back-to-back reads at full rate.
        for (int i = 0; i < 4; i++) issue_now(1'b1, AW'(i), 64'hA0 + DW'(i), "wr_seq_ready");
        for (int i = 0; i < 4; i++) issue_now(1'b0, AW'(i), 64'h0, "rd_seq_ready");
        idle(4);
        check("rd_seq_rsp_count", n_rsp, 5);

        // Read @5 followed immediately by a write @6: one TURN bubble.
        issue_now(1'b1, 10'd5, 64'h5555AAAA5555AAAA, "t_pre_wr_ready");
        idle(1);
        issue_now(1'b0, 10'd5, 64'h0, "t_rd_ready");
        bus.req_we    = 1'b1;
        bus.req_addr  = 10'd6;
        bus.req_wdata = 64'h0000000000006666;
        #1 check("t_turn_ready_low", bus.req_ready, 0);
        step();
        check("t_turn_cmd", {sram_csb, sram_web, sram_oeb}, 3'b010);
        check("t_turn_addr", sram_addr, 10'd5);
        check("t_capture_bus", sram_data, 64'h5555AAAA5555AAAA);
        #1 check("t_turn_ready_high", bus.req_ready, 1);
        step();
        check("t_wr_cmd", {sram_csb, sram_web, sram_oeb}, 3'b001);
        check("t_wr_addr", sram_addr, 10'd6);
        issue_now(1'b0, 10'd6, 64'h0, "t_rd6_ready");
        idle(4);
        check("t_rsp_count", n_rsp, 7);

        // Consumer stalled: only 4 reads fit, writes still flow.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue_now(1'b0, AW'(i), 64'h0, "cr_rd_ready");
        bus.req_addr = 10'd5;
        for (int i = 0; i < 3; i++) begin
            #1 check("cr_read_blocked", bus.req_ready, 0);
            step();
        end
        bus.req_we    = 1'b1;
        bus.req_addr  = 10'd7;
        bus.req_wdata = 64'h77;
        #1 check("cr_write_passes", bus.req_ready, 1);
        step();
        bus.req_valid = 1'b0;
        check("cr_full_valid", bus.rsp_valid, 1);
        check("cr_head", bus.rsp_rdata, 64'hA0);
        step();
        check("cr_head_stable", bus.rsp_rdata, 64'hA0);
        bus.rsp_ready = 1'b1;
        issue(1'b0, 10'd5, 64'h0);
        issue(1'b0, 10'd6, 64'h0);
        idle(8);
        check("cr_rsp_count", n_rsp, 13);

        // Reset in the cycle after a read accept discards that read.
        issue_now(1'b0, 10'h3FF, 64'h0, "rr_rd_ready");
        bus.req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_no_rsp", bus.rsp_valid, 0);
        end
        check("rr_cmd_idle", {sram_csb, sram_web, sram_oeb}, 3'b111);
        issue_now(1'b0, 10'd3, 64'h0, "rr_rd3_ready");
        idle(4);
        check("rr_rsp_count", n_rsp, 14);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Time limit so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, required finish before 200000", $time);
        $fatal(1);
    end

endmodule
